// File: rtl/tp_pingpong_ctrl.sv
// Ping-pong bank controller for the DCT transpose buffer: rows are written into one
// bank while the other bank is drained column by column. Optional macro: TP_PINGPONG_CTRL_ERR_EN.
module tp_pingpong_ctrl #(
    parameter int ROWS = 8,
    parameter int IW   = 3
) (
    input  logic          i_clk,
    input  logic          i_Reset,
    input  logic          i_valid,
    output logic          o_in_ready,
    output logic [1:0]    o_wr_en,
    output logic [IW-1:0] o_wr_idx,
    input  logic          i_out_ready,
    output logic          o_rd_en,
    output logic          o_rd_bank,
    output logic [IW-1:0] o_rd_idx,
    output logic          o_out_valid,
    output logic          o_block_done,
    output logic          o_err
);

    typedef enum logic [1:0] {
        EMPTY    = 2'd0,
        FILLING  = 2'd1,
        FULL     = 2'd2,
        DRAINING = 2'd3
    } bank_state_e;

    localparam logic [IW-1:0] LAST_IDX = IW'(ROWS - 1);

    bank_state_e   bank_q [2];
    bank_state_e   bank_d [2];
    logic          wbank_q, wbank_d;
    logic          rbank_q, rbank_d;
    logic [IW-1:0] wcnt_q, wcnt_d;
    logic [IW-1:0] rcnt_q, rcnt_d;
    logic          out_valid_q, out_valid_d;
    logic          block_done_q, block_done_d;

    logic          wr_open;
    logic          rd_avail;
    logic          wr_fire;
    logic          rd_fire;
    logic          wr_last;
    logic          rd_last;
    logic [1:0]    wr_sel;
    logic [1:0]    rd_sel;

    // Write and read can never target the same bank in one cycle, so both updates compose.
    function automatic bank_state_e bank_next(
        input bank_state_e st,
        input logic        wr,
        input logic        wr_end,
        input logic        rd,
        input logic        rd_end
    );
        bank_state_e nxt;
        nxt = st;
        if (wr) begin
            nxt = wr_end ? FULL : FILLING;
        end
        if (rd) begin
            nxt = rd_end ? EMPTY : DRAINING;
        end
        return nxt;
    endfunction

    always_comb begin
        wr_open  = (bank_q[wbank_q] == EMPTY) || (bank_q[wbank_q] == FILLING);
        rd_avail = (bank_q[rbank_q] == FULL)  || (bank_q[rbank_q] == DRAINING);
        // Gated by reset so an asserted i_valid cannot strobe a bank while in reset.
        wr_fire  = i_valid && wr_open && i_Reset;
        rd_fire  = rd_avail && i_out_ready;
        wr_last  = wr_fire && (wcnt_q == LAST_IDX);
        rd_last  = rd_fire && (rcnt_q == LAST_IDX);
        wr_sel   = {wr_fire && wbank_q, wr_fire && !wbank_q};
        rd_sel   = {rd_fire && rbank_q, rd_fire && !rbank_q};

        bank_d[0]    = bank_next(bank_q[0], wr_sel[0], wr_last, rd_sel[0], rd_last);
        bank_d[1]    = bank_next(bank_q[1], wr_sel[1], wr_last, rd_sel[1], rd_last);
        wcnt_d       = wr_fire ? wcnt_q + IW'(1) : wcnt_q;
        rcnt_d       = rd_fire ? rcnt_q + IW'(1) : rcnt_q;
        wbank_d      = wbank_q ^ wr_last;
        rbank_d      = rbank_q ^ rd_last;
        out_valid_d  = rd_fire;
        block_done_d = rd_last;
    end

    always_ff @(posedge i_clk or negedge i_Reset) begin
        if (!i_Reset) begin
            bank_q[0]    <= EMPTY;
            bank_q[1]    <= EMPTY;
            wbank_q      <= 1'b0;
            rbank_q      <= 1'b0;
            wcnt_q       <= '0;
            rcnt_q       <= '0;
            out_valid_q  <= 1'b0;
            block_done_q <= 1'b0;
        end else begin
            bank_q[0]    <= bank_d[0];
            bank_q[1]    <= bank_d[1];
            wbank_q      <= wbank_d;
            rbank_q      <= rbank_d;
            wcnt_q       <= wcnt_d;
            rcnt_q       <= rcnt_d;
            out_valid_q  <= out_valid_d;
            block_done_q <= block_done_d;
        end
    end

`ifdef TP_PINGPONG_CTRL_ERR_EN
    logic err_q, err_d;

    // Sticky: any row offered while the write bank is still occupied.
    always_comb begin
        err_d = err_q || (i_valid && !wr_open);
    end

    always_ff @(posedge i_clk or negedge i_Reset) begin
        if (!i_Reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign o_err = err_q;
`else
    assign o_err = 1'b0;
`endif

    assign o_in_ready   = wr_open;
    assign o_wr_en      = wr_sel;
    assign o_wr_idx     = wcnt_q;
    assign o_rd_en      = rd_fire;
    assign o_rd_bank    = rbank_q;
    assign o_rd_idx     = rcnt_q;
    assign o_out_valid  = out_valid_q;
    assign o_block_done = block_done_q;

endmodule

// File: tb/tb_tp_pingpong_ctrl.sv
// Self-checking bench for tp_pingpong_ctrl: vector table, directed corner sequences and
// randomized traffic checked against a block-counting reference model.
module tb_tp_pingpong_ctrl;

    localparam int ROWS = 8;
    localparam int IW   = 3;

    logic          clk;
    logic          i_Reset;
    logic          i_valid;
    logic          o_in_ready;
    logic [1:0]    o_wr_en;
    logic [IW-1:0] o_wr_idx;
    logic          i_out_ready;
    logic          o_rd_en;
    logic          o_rd_bank;
    logic [IW-1:0] o_rd_idx;
    logic          o_out_valid;
    logic          o_block_done;
    logic          o_err;

    tp_pingpong_ctrl #(.ROWS(ROWS), .IW(IW)) dut (
        .i_clk        (clk),
        .i_Reset      (i_Reset),
        .i_valid      (i_valid),
        .o_in_ready   (o_in_ready),
        .o_wr_en      (o_wr_en),
        .o_wr_idx     (o_wr_idx),
        .i_out_ready  (i_out_ready),
        .o_rd_en      (o_rd_en),
        .o_rd_bank    (o_rd_bank),
        .o_rd_idx     (o_rd_idx),
        .o_out_valid  (o_out_valid),
        .o_block_done (o_block_done),
        .o_err        (o_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef TP_PINGPONG_CTRL_ERR_EN
    localparam int ERR_BUILT = 1;
`else
    localparam int ERR_BUILT = 0;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: blocks completed on each side plus progress in the current block.
    int nw, nr, wr_rows, rd_cols;
    int m_ov, m_done, m_err;

    // Values seen at the most recent sample point.
    int s_in_ready, s_wr_en, s_wr_idx, s_rd_en, s_rd_bank, s_rd_idx, s_ov, s_done, s_err;

    typedef struct {
        logic v;
        logic r;
        int   in_ready;
        int   wr_en;
        int   wr_idx;
        int   rd_en;
        int   rd_bank;
        int   rd_idx;
        int   ov;
        int   done;
    } vec_t;

    vec_t tbl [18];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        nw = 0; nr = 0; wr_rows = 0; rd_cols = 0;
        m_ov = 0; m_done = 0; m_err = 0;
    endtask

    task automatic sample();
        s_in_ready = int'(o_in_ready);
        s_wr_en    = int'(o_wr_en);
        s_wr_idx   = int'(o_wr_idx);
        s_rd_en    = int'(o_rd_en);
        s_rd_bank  = int'(o_rd_bank);
        s_rd_idx   = int'(o_rd_idx);
        s_ov       = int'(o_out_valid);
        s_done     = int'(o_block_done);
        s_err      = int'(o_err);
    endtask

    // One clock cycle: drive at negedge, compare against the model, advance the model at posedge.
    task automatic step(input logic v, input logic r);
        int held, e_in_ready, e_wr_fire, e_rd_en;
        @(negedge clk);
        i_valid     = v;
        i_out_ready = r;
        #1;
        sample();
        held       = nw - nr;
        e_in_ready = (held < 2) ? 1 : 0;
        e_wr_fire  = (v && e_in_ready != 0) ? 1 : 0;
        e_rd_en    = (held > 0 && r) ? 1 : 0;
        chk("in_ready",   s_in_ready, e_in_ready);
        chk("wr_en",      s_wr_en,    e_wr_fire != 0 ? (1 << (nw % 2)) : 0);
        chk("wr_idx",     s_wr_idx,   wr_rows);
        chk("rd_en",      s_rd_en,    e_rd_en);
        chk("rd_bank",    s_rd_bank,  nr % 2);
        chk("rd_idx",     s_rd_idx,   rd_cols);
        chk("out_valid",  s_ov,       m_ov);
        chk("block_done", s_done,     m_done);
        chk("err",        s_err,      m_err);
        @(posedge clk);
        if (e_wr_fire != 0) begin
            wr_rows++;
            if (wr_rows == ROWS) begin
                wr_rows = 0;
                nw++;
            end
        end
        m_done = 0;
        if (e_rd_en != 0) begin
            rd_cols++;
            if (rd_cols == ROWS) begin
                rd_cols = 0;
                nr++;
                m_done = 1;
            end
        end
        m_ov = e_rd_en;
        if (ERR_BUILT != 0 && v && e_in_ready == 0) m_err = 1;
    endtask

    // Asserts reset away from the clock edge with i_valid high and checks outputs at once.
    task automatic do_reset();
        @(negedge clk);
        i_Reset     = 1'b0;
        i_valid     = 1'b1;
        i_out_ready = 1'b1;
        #1;
        sample();
        chk("rst_in_ready",   s_in_ready, 1);
        chk("rst_wr_en",      s_wr_en,    0);
        chk("rst_wr_idx",     s_wr_idx,   0);
        chk("rst_rd_en",      s_rd_en,    0);
        chk("rst_rd_bank",    s_rd_bank,  0);
        chk("rst_rd_idx",     s_rd_idx,   0);
        chk("rst_out_valid",  s_ov,       0);
        chk("rst_block_done", s_done,     0);
        chk("rst_err",        s_err,      0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        i_Reset = 1'b1;
        i_valid = 1'b0;
    endtask

    initial begin
        int ov_cnt, done_cnt, pv, pr;
        int banks [$];

        for (int k = 0; k < 18; k++) begin
            tbl[k].v        = (k < 8);
            tbl[k].r        = 1'b1;
            tbl[k].in_ready = 1;
            tbl[k].wr_en    = (k < 8) ? 1 : 0;
            tbl[k].wr_idx   = (k < 8) ? k : 0;
            tbl[k].rd_en    = (k >= 8 && k < 16) ? 1 : 0;
            tbl[k].rd_bank  = (k < 16) ? 0 : 1;
            tbl[k].rd_idx   = (k >= 8 && k < 16) ? k - 8 : 0;
            tbl[k].ov       = (k >= 9 && k <= 16) ? 1 : 0;
            tbl[k].done     = (k == 16) ? 1 : 0;
        end

        i_Reset     = 1'b0;
        i_valid     = 1'b0;
        i_out_ready = 1'b0;
        model_reset();
        do_reset();

        // Single block back-to-back with downstream always ready.
        for (int k = 0; k < 18; k++) begin
            step(tbl[k].v, tbl[k].r);
            chk("tbl_in_ready",  s_in_ready, tbl[k].in_ready);
            chk("tbl_wr_en",     s_wr_en,    tbl[k].wr_en);
            if (tbl[k].wr_en != 0) chk("tbl_wr_idx", s_wr_idx, tbl[k].wr_idx);
            chk("tbl_rd_en",     s_rd_en,    tbl[k].rd_en);
            chk("tbl_rd_bank",   s_rd_bank,  tbl[k].rd_bank);
            chk("tbl_rd_idx",    s_rd_idx,   tbl[k].rd_idx);
            chk("tbl_out_valid", s_ov,       tbl[k].ov);
            chk("tbl_done",      s_done,     tbl[k].done);
        end

        // Three blocks streamed continuously.
        do_reset();
        banks.delete();
        for (int k = 0; k < 36; k++) begin
            step(k < 24, 1'b1);
            if (k < 24) chk("stream_in_ready", s_in_ready, 1);
            if (k < 24) chk("stream_wr_en", s_wr_en, ((k / 8) % 2 == 0) ? 1 : 2);
            if (s_rd_en != 0 && s_rd_idx == 0) banks.push_back(s_rd_bank);
        end
        chk("stream_nblocks", banks.size(), 3);
        if (banks.size() == 3) begin
            chk("stream_bank0", banks[0], 0);
            chk("stream_bank1", banks[1], 1);
            chk("stream_bank2", banks[2], 0);
        end

        // Both banks full with downstream stalled, then an extra row.
        do_reset();
        for (int k = 0; k < 16; k++) step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        chk("ovf_in_ready", s_in_ready, 0);
        chk("ovf_wr_en",    s_wr_en,    0);
        step(1'b0, 1'b0);
        chk("ovf_err",      s_err,      ERR_BUILT);
        for (int k = 0; k < 18; k++) step(1'b0, 1'b1);
        chk("ovf_err_sticky", s_err, ERR_BUILT);

        // Drain with downstream ready toggling every cycle.
        do_reset();
        for (int k = 0; k < 8; k++) step(1'b1, 1'b0);
        ov_cnt = 0;
        done_cnt = 0;
        for (int k = 0; k < 18; k++) begin
            step(1'b0, (k % 2) == 0);
            if ((k % 2) == 0 && k < 16) chk("toggle_rd_idx", s_rd_idx, k / 2);
            ov_cnt   += s_ov;
            done_cnt += s_done;
        end
        chk("toggle_ov_count",   ov_cnt,   8);
        chk("toggle_done_count", done_cnt, 1);

        // Reset in the middle of a block discards it.
        do_reset();
        for (int k = 0; k < 5; k++) step(1'b1, 1'b1);
        chk("mid_wr_idx_before", s_wr_idx, 4);
        do_reset();
        step(1'b1, 1'b1);
        chk("post_rst_wr_en",  s_wr_en,  1);
        chk("post_rst_wr_idx", s_wr_idx, 0);
        for (int k = 0; k < 20; k++) step(k < 7, 1'b1);

        // Randomized traffic with varying load and occasional resets.
        for (int seg = 0; seg < 6; seg++) begin
            pv = 20 + seg * 15;
            pr = 90 - seg * 15;
            for (int k = 0; k < 500; k++) begin
                if ($urandom_range(0, 399) == 0) do_reset();
                step($urandom_range(0, 99) < pv, $urandom_range(0, 99) < pr);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
